// File: rtl/ram8_arbiter.sv
// ram8_arbiter: round-robin req/ack arbiter sharing one RAM8 between two clients,
// with an optional zero-fill of every word after reset.
module ram8_arbiter #(
   parameter int WIDTH = 16,
   parameter int AW = 3,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   output logic             a_ack,
   output logic [WIDTH-1:0] a_rdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [AW-1:0]    b_addr,
   input  logic [WIDTH-1:0] b_wdata,
   output logic             b_ack,
   output logic [WIDTH-1:0] b_rdata,
   output logic [WIDTH-1:0] ram_in,
   output logic [AW-1:0]    ram_address,
   output logic             ram_load,
   input  logic [WIDTH-1:0] ram_out,
   output logic             busy
);
   typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, ACK} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] clr_cnt;
   logic g, last, grant_b, load;
   logic g_we;
   logic [AW-1:0] g_addr;
   logic [WIDTH-1:0] g_wdata;
   // g/last: 0 = A, 1 = B; B only wins a tie when A was served last
   assign grant_b = b_req & ~(a_req & last);
   assign g_we = g ? b_we : a_we;
   assign g_addr = g ? b_addr : a_addr;
   assign g_wdata = g ? b_wdata : a_wdata;
   assign a_ack = (state == ACK) & ~g;
   assign b_ack = (state == ACK) & g;
   assign busy = state == CLEAR;
   // reset must drop the write strobe at once, even though state already sits in CLEAR
   assign ram_load = load & reset_n;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_cnt <= '0;
         g <= 1'b0;
         last <= 1'b1;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (state == IDLE && (a_req || b_req)) begin
            g <= grant_b;
            last <= grant_b;
         end
         if (state == ACCESS && !g_we && !g) a_rdata <= ram_out;
         if (state == ACCESS && !g_we && g) b_rdata <= ram_out;
      end
   end
   always_comb begin
      state_nxt = state;
      load = 1'b0;
      ram_address = '0;
      ram_in = '0;
      case (state)
         CLEAR: begin
            load = 1'b1;
            ram_address = clr_cnt;
            state_nxt = &clr_cnt ? IDLE : CLEAR;
         end
         IDLE: state_nxt = (a_req || b_req) ? ACCESS : IDLE;
         ACCESS: begin
            load = g_we;
            ram_address = g_addr;
            ram_in = g_wdata;
            state_nxt = ACK;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter: directed checks of clear, arbitration, handshake timing and reset abort.
module tb_ram8_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [2:0] a_addr = '0, b_addr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic a_ack, b_ack, ram_load, busy;
   logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
   logic [2:0] ram_address;
   logic [15:0] mem [0:7] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                              16'h5555, 16'h6666, 16'h7777, 16'h8888};
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic sel_b;
      logic we;
      logic [2:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } vec_t;
   vec_t tbl [8];

   always #5 clock = ~clock;
   assign ram_out = mem[ram_address];
   always @(posedge clock) if (ram_load) mem[ram_address] <= ram_in;

   ram8_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out), .busy(busy)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // called right after reset_n is released on a negedge
   task automatic run_clear(input bit raise_b);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk1("clr_busy", busy, 1'b1);
         chk1("clr_load", ram_load, 1'b1);
         chk16("clr_addr", 16'(ram_address), 16'(i));
         chk16("clr_in", ram_in, 16'h0);
         chk1("clr_ack", a_ack | b_ack, 1'b0);
         if (raise_b && i == 2) begin
            b_req = 1'b1;
            b_we = 1'b0;
            b_addr = 3'd3;
         end
         @(negedge clock);
      end
      #1;
      chk1("clr_done_busy", busy, 1'b0);
      chk1("clr_done_load", ram_load, 1'b0);
   endtask

   // entered in the IDLE cycle where the request is first sampled
   task automatic wait_ack(input logic sel_b, input logic we, input logic [2:0] addr, input logic [15:0] wd);
      int got = 0;
      for (int n = 1; n <= 6 && got == 0; n++) begin
         @(negedge clock);
         #1;
         if (n == 1) begin
            chk16("acc_addr", 16'(ram_address), 16'(addr));
            chk1("acc_load", ram_load, we);
            chk16("acc_in", ram_in, wd);
         end
         chk1("other_ack", sel_b ? a_ack : b_ack, 1'b0);
         if (sel_b ? b_ack : a_ack) got = n;
      end
      chk16("ack_latency", 16'(got), 16'd2);
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic txn(input vec_t v);
      @(negedge clock);
      if (v.sel_b) begin
         b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
      end else begin
         a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
      end
      #1;
      chk1("idle_ack", a_ack | b_ack, 1'b0);
      wait_ack(v.sel_b, v.we, v.addr, v.wdata);
      chk16("a_rdata", a_rdata, v.exp_a);
      chk16("b_rdata", b_rdata, v.exp_b);
   endtask

   initial begin
      int k = 0;
      int ack_cyc [4];
      logic who [4];
      int exp_cyc [4] = '{2, 5, 8, 11};
      logic exp_who [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] exp_rd [4] = '{16'hBEEF, 16'h1234, 16'hCAFE, 16'hBEEF};
      tbl[0] = '{1'b0, 1'b1, 3'd5, 16'hBEEF, 16'h0000, 16'h0000};
      tbl[1] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'h0000, 16'hBEEF};
      tbl[2] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h0000, 16'hBEEF};
      tbl[3] = '{1'b0, 1'b1, 3'd3, 16'h1234, 16'h0000, 16'hBEEF};
      tbl[4] = '{1'b1, 1'b1, 3'd7, 16'hCAFE, 16'h0000, 16'hBEEF};
      tbl[5] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h1234, 16'hBEEF};
      tbl[6] = '{1'b0, 1'b0, 3'd7, 16'h0000, 16'hCAFE, 16'hBEEF};
      tbl[7] = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'hCAFE, 16'hCAFE};
      repeat (2) @(negedge clock);
      #1;
      chk1("rst_busy", busy, 1'b1);
      chk1("rst_load", ram_load, 1'b0);
      chk1("rst_ack", a_ack | b_ack, 1'b0);
      chk16("rst_a_rdata", a_rdata, 16'h0);
      chk16("rst_b_rdata", b_rdata, 16'h0);
      @(negedge clock);
      reset_n = 1'b1;
      run_clear(1'b1);
      wait_ack(1'b1, 1'b0, 3'd3, 16'h0);
      chk16("clr_b_rdata", b_rdata, 16'h0);
      foreach (tbl[i]) txn(tbl[i]);
      @(negedge clock);
      a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 3'd3;
      for (int c = 1; c <= 20 && k < 4; c++) begin
         @(negedge clock);
         #1;
         chk1("no_overlap", a_ack & b_ack, 1'b0);
         if (a_ack || b_ack) begin
            who[k] = b_ack;
            ack_cyc[k] = c;
            chk16("tie_rdata", b_ack ? b_rdata : a_rdata, exp_rd[k]);
            if (a_ack) a_req = 1'b0;
            else b_req = 1'b0;
            k++;
            if (k == 2) begin
               a_req = 1'b1; a_addr = 3'd7;
               b_req = 1'b1; b_addr = 3'd5;
            end
         end
      end
      chk16("tie_count", 16'(k), 16'd4);
      for (int j = 0; j < k; j++) begin
         chk1("tie_order", who[j], exp_who[j]);
         chk16("tie_cycle", 16'(ack_cyc[j]), 16'(exp_cyc[j]));
      end
      @(negedge clock);
      a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 16'h5555;
      @(negedge clock);
      #1;
      chk1("abort_acc_load", ram_load, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk1("abort_load", ram_load, 1'b0);
      chk1("abort_ack", a_ack, 1'b0);
      chk1("abort_busy", busy, 1'b1);
      chk16("abort_a_rdata", a_rdata, 16'h0);
      a_req = 1'b0;
      @(negedge clock);
      chk1("abort_no_ack", a_ack, 1'b0);
      reset_n = 1'b1;
      run_clear(1'b0);
      txn('{1'b0, 1'b0, 3'd5, 16'h0000, 16'h0000, 16'h0000});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
